// File: rtl/sd_dat_responder_pkg.sv
// Shared constants, state encoding and CRC16 step for the SD DAT[3:0] card-side responder.
package sd_dat_responder_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;   // x^16 + x^12 + x^5 + 1
  localparam logic [3:0]  START_NIB  = 4'h0;
  localparam logic [3:0]  END_NIB    = 4'hF;
  localparam logic [3:0]  IDLE_NIB   = 4'hF;
  localparam logic [3:0]  BUSY_NIB   = 4'b1110;
  localparam logic [2:0]  TOKEN_PASS = 3'b010;
  localparam logic [2:0]  TOKEN_FAIL = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_WAIT,
    S_RX_DATA,
    S_RX_CRC,
    S_RX_END,
    S_ST_GAP,
    S_ST_TOKEN,
    S_BUSY,
    S_TX_WAIT,
    S_TX_START,
    S_TX_DATA,
    S_TX_CRC,
    S_TX_END,
    S_DONE
  } state_t;

  // Full status frame on DAT0, sent MSB first: start 0, three status bits, end 1.
  function automatic logic [4:0] status_token(input logic fail);
    return {1'b0, (fail ? TOKEN_FAIL : TOKEN_PASS), 1'b1};
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_dat_responder_crc16.sv
// Serial one-bit CRC16 for a single DAT line; clear has priority over enable.
module sd_crc16
  import sd_dat_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/sd_dat_responder.sv
// Card-side SD DAT[3:0] responder: receives host write blocks with CRC status/busy reply,
// and transmits read blocks from an external synchronous nibble buffer.
module sd_dat_responder
  import sd_dat_responder_pkg::*;
#(
  parameter int BLOCK_NIBBLES = 1024,
  parameter int ADDR_W        = 10,
  parameter int NAC_CYCLES    = 2,
  parameter int BUSY_CYCLES   = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [3:0]        idata_sd,
  output logic [3:0]        odata_sd,
  output logic              ooe,
  input  logic              istart_recv,
  input  logic              istart_send,
  output logic [ADDR_W-1:0] oaddr,
  output logic [3:0]        owdata,
  output logic              owrite_en,
  input  logic [3:0]        irdata,
  output logic              ocrc_fail,
  output logic              odone,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_NIB  = ADDR_W'(BLOCK_NIBBLES - 1);
  localparam logic [ADDR_W-1:0] NAC_LAST  = ADDR_W'(NAC_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BUSY_LAST = ADDR_W'(BUSY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] CRC_LAST  = ADDR_W'(15);
  localparam logic [ADDR_W-1:0] GAP_LAST  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TOK_LAST  = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              crc_err;
  logic              crc_clr;
  logic              crc_en;
  logic [3:0]        crc_din;
  logic [3:0][15:0]  crc_q;
  logic [3:0]        crc_bit_idx;
  logic [3:0]        crc_nib;
  logic [4:0]        tok;

  assign dbg_state = state;
  assign tok       = status_token(ocrc_fail);

  for (genvar l = 0; l < 4; l++) begin : g_crc
    sd_crc16 u_crc (
      .clk (iclk),
      .rst (irst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (crc_din[l]),
      .crc (crc_q[l])
    );
  end

  // RX feeds the bus nibble; TX feeds the RAM nibble on the edge it is registered onto the bus.
  always_comb begin
    crc_clr = (state == S_IDLE);
    crc_en  = 1'b0;
    crc_din = idata_sd;
    case (state)
      S_RX_DATA:  crc_en = 1'b1;
      S_TX_START: begin
        crc_en  = 1'b1;
        crc_din = irdata;
      end
      S_TX_DATA: begin
        crc_en  = (cnt != LAST_NIB);
        crc_din = irdata;
      end
      default: ;
    endcase
  end

  // RX compares the bit on the bus now; TX loads the bit for the next bus cycle.
  always_comb begin
    crc_bit_idx = 4'd15;
    if (state == S_RX_CRC) begin
      crc_bit_idx = 4'd15 - cnt[3:0];
    end else if (state == S_TX_CRC) begin
      crc_bit_idx = 4'd14 - cnt[3:0];
    end
    crc_nib = '0;
    for (int l = 0; l < 4; l++) begin
      crc_nib[l] = crc_q[l][crc_bit_idx];
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      crc_err   <= 1'b0;
      odata_sd  <= IDLE_NIB;
      ooe       <= 1'b0;
      oaddr     <= '0;
      owdata    <= '0;
      owrite_en <= 1'b0;
      ocrc_fail <= 1'b0;
      odone     <= 1'b0;
    end else begin
      odone     <= 1'b0;
      owrite_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (istart_recv) begin
            state     <= S_RX_WAIT;
            ocrc_fail <= 1'b0;
          end else if (istart_send) begin
            state <= S_TX_WAIT;
            cnt   <= '0;
            oaddr <= '0;
          end
        end
        S_RX_WAIT: begin
          if (idata_sd == START_NIB) begin
            state   <= S_RX_DATA;
            cnt     <= '0;
            crc_err <= 1'b0;
          end
        end
        S_RX_DATA: begin
          owrite_en <= 1'b1;
          oaddr     <= cnt;
          owdata    <= idata_sd;
          if (cnt == LAST_NIB) begin
            state <= S_RX_CRC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RX_CRC: begin
          crc_err <= crc_err | (idata_sd != crc_nib);
          if (cnt == CRC_LAST) begin
            state <= S_RX_END;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RX_END: begin
          ocrc_fail <= crc_err | (idata_sd != END_NIB);
          state     <= S_ST_GAP;
          cnt       <= '0;
        end
        S_ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state    <= S_ST_TOKEN;
            cnt      <= '0;
            ooe      <= 1'b1;
            odata_sd <= {3'b111, tok[4]};
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_ST_TOKEN: begin
          if (cnt == TOK_LAST) begin
            state    <= S_BUSY;
            cnt      <= '0;
            odata_sd <= BUSY_NIB;
          end else begin
            cnt      <= cnt + CNT_ONE;
            odata_sd <= {3'b111, tok[3'd3 - cnt[2:0]]};
          end
        end
        S_BUSY: begin
          if (cnt == BUSY_LAST) begin
            state    <= S_DONE;
            ooe      <= 1'b0;
            odata_sd <= IDLE_NIB;
            odone    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_TX_WAIT: begin
          if (cnt == NAC_LAST) begin
            state    <= S_TX_START;
            ooe      <= 1'b1;
            odata_sd <= START_NIB;
            oaddr    <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_TX_START: begin
          state    <= S_TX_DATA;
          cnt      <= '0;
          odata_sd <= irdata;
          oaddr    <= oaddr + CNT_ONE;
        end
        S_TX_DATA: begin
          if (cnt == LAST_NIB) begin
            state    <= S_TX_CRC;
            cnt      <= '0;
            odata_sd <= crc_nib;
          end else begin
            cnt      <= cnt + CNT_ONE;
            odata_sd <= irdata;
            if (oaddr != LAST_NIB) begin
              oaddr <= oaddr + CNT_ONE;
            end
          end
        end
        S_TX_CRC: begin
          if (cnt == CRC_LAST) begin
            state    <= S_TX_END;
            odata_sd <= END_NIB;
          end else begin
            cnt      <= cnt + CNT_ONE;
            odata_sd <= crc_nib;
          end
        end
        S_TX_END: begin
          state    <= S_DONE;
          ooe      <= 1'b0;
          odata_sd <= IDLE_NIB;
          odone    <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_responder.sv
// Bench for sd_dat_responder: reset abort, table-driven and random host writes, read blocks.
module tb_sd_dat_responder;
  import sd_dat_responder_pkg::*;

  localparam int BLOCK = 1024;

  logic       clk;
  logic       rst;
  logic [3:0] idata;
  logic [3:0] odata;
  logic       ooe;
  logic       istart_recv;
  logic       istart_send;
  logic [9:0] oaddr;
  logic [3:0] owdata;
  logic       owrite_en;
  logic [3:0] irdata;
  logic       ocrc_fail;
  logic       odone;
  state_t     dbg_state;

  logic       ld_en;
  logic [9:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] mem [BLOCK];
  logic [3:0] blk [BLOCK];

  logic [13:0] exp_q[$];
  int          checks;
  int          errors;
  bit          exp_fail_state;

  typedef struct {
    int         pattern;   // 0 zeros, 1 n[3:0], 2 random
    int         flip_line; // -1: no CRC corruption
    int         flip_bit;
    logic [3:0] end_nib;
    bit         extras;
    bit         exp_fail;
  } rx_vec_t;

  rx_vec_t rx_tab[5];

  sd_dat_responder dut (
    .iclk        (clk),
    .irst        (rst),
    .idata_sd    (idata),
    .odata_sd    (odata),
    .ooe         (ooe),
    .istart_recv (istart_recv),
    .istart_send (istart_send),
    .oaddr       (oaddr),
    .owdata      (owdata),
    .owrite_en   (owrite_en),
    .irdata      (irdata),
    .ocrc_fail   (ocrc_fail),
    .odone       (odone),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // synchronous nibble RAM with a bench-side preload port
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (owrite_en) begin
      mem[oaddr] <= owdata;
    end
    irdata <= mem[oaddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard for buffer writes
  always @(negedge clk) begin
    if (owrite_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h with no write expected", oaddr, owdata);
      end else begin
        check("rx_write", 32'({oaddr, owdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CRC16 as remainder of the augmented message (data * x^16) divided by the generator
  function automatic logic [15:0] crc_ref(input int line);
    logic [16:0] r;
    logic        b;
    r = '0;
    for (int k = 0; k < BLOCK + 16; k++) begin
      b = (k < BLOCK) ? blk[k][line] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic fill_block(input int pattern);
    for (int k = 0; k < BLOCK; k++) begin
      if (pattern == 0)      blk[k] = 4'h0;
      else if (pattern == 1) blk[k] = 4'(k);
      else                   blk[k] = 4'($urandom_range(0, 15));
    end
  endtask

  // driver: host write block, then status token / busy / done checks
  task automatic do_receive(input rx_vec_t v, input string tag);
    logic [15:0] crc [4];
    logic [4:0]  tok;
    int          n_idle;
    fill_block(v.pattern);
    for (int l = 0; l < 4; l++) begin
      crc[l] = crc_ref(l);
      if (v.flip_line == l) crc[l][v.flip_bit] = ~crc[l][v.flip_bit];
    end
    tok = {1'b0, (v.exp_fail ? 3'b101 : 3'b010), 1'b1};

    idata = 4'hF;
    istart_recv = 1'b1;
    istart_send = v.extras;
    step();
    istart_recv = 1'b0;
    istart_send = 1'b0;
    check({tag, "_fail_cleared"}, 32'(ocrc_fail), 32'(0));
    check({tag, "_in_rx_wait"}, 32'(dbg_state), 32'(S_RX_WAIT));

    n_idle = $urandom_range(1, 5);
    for (int i = 0; i < n_idle; i++) begin
      istart_send = (v.extras && i == 0);
      step();
    end
    istart_send = 1'b0;

    idata = 4'h0;
    step();
    for (int k = 0; k < BLOCK; k++) begin
      idata = blk[k];
      exp_q.push_back({10'(k), blk[k]});
      istart_recv = (v.extras && k == 100);
      istart_send = (v.extras && k == 100);
      step();
    end
    istart_recv = 1'b0;
    istart_send = 1'b0;
    for (int b = 0; b < 16; b++) begin
      idata = {crc[3][15-b], crc[2][15-b], crc[1][15-b], crc[0][15-b]};
      step();
    end
    idata = v.end_nib;
    step();
    idata = 4'hF;

    check({tag, "_crc_fail"}, 32'(ocrc_fail), 32'(v.exp_fail));
    check({tag, "_gap0"}, 32'({ooe, odata}), 32'({1'b0, 4'hF}));
    step();
    check({tag, "_gap1"}, 32'(ooe), 32'(0));
    step();
    for (int c = 0; c < 5; c++) begin
      check({tag, "_token"}, 32'({ooe, odata}), 32'({1'b1, 3'b111, tok[4-c]}));
      istart_send = (v.extras && c == 2);
      step();
    end
    istart_send = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check({tag, "_busy"}, 32'({ooe, odata}), 32'({1'b1, 4'b1110}));
      step();
    end
    check({tag, "_done"}, 32'({ooe, odata, odone}), 32'({1'b0, 4'hF, 1'b1}));
    step();
    check({tag, "_idle"}, 32'({odone, 4'(dbg_state)}), 32'({1'b0, 4'(S_IDLE)}));
    check({tag, "_all_writes_seen"}, 32'(exp_q.size()), 32'(0));
    exp_fail_state = v.exp_fail;
    if (v.extras) begin
      for (int i = 0; i < 4; i++) begin
        step();
        check({tag, "_no_late_send"}, 32'(ooe), 32'(0));
      end
    end
  endtask

  // driver: preload buffer, request read block, check the DAT stream
  task automatic do_send(input int pattern, input bit poke, input string tag);
    logic [15:0] got_crc [4];
    fill_block(pattern);
    for (int k = 0; k < BLOCK; k++) begin
      ld_en   = 1'b1;
      ld_addr = 10'(k);
      ld_data = blk[k];
      step();
    end
    ld_en = 1'b0;

    istart_send = 1'b1;
    step();
    istart_send = 1'b0;
    check({tag, "_nac0_oe"}, 32'(ooe), 32'(0));
    step();
    check({tag, "_nac1_oe"}, 32'(ooe), 32'(0));
    check({tag, "_prefetch_addr"}, 32'(oaddr), 32'(0));
    step();
    check({tag, "_start_bit"}, 32'({ooe, odata}), 32'({1'b1, 4'h0}));
    step();
    for (int k = 0; k < BLOCK; k++) begin
      check({tag, "_data"}, 32'({ooe, odata}), 32'({1'b1, blk[k]}));
      istart_recv = (poke && k == 500);
      step();
    end
    istart_recv = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 4; l++) got_crc[l][15-b] = odata[l];
      check({tag, "_crc_oe"}, 32'(ooe), 32'(1));
      step();
    end
    for (int l = 0; l < 4; l++) begin
      check({tag, "_crc_line"}, 32'(got_crc[l]), 32'(crc_ref(l)));
    end
    check({tag, "_end_bit"}, 32'({ooe, odata}), 32'({1'b1, 4'hF}));
    step();
    check({tag, "_done"}, 32'({ooe, odata, odone}), 32'({1'b0, 4'hF, 1'b1}));
    step();
    check({tag, "_idle"}, 32'({odone, 4'(dbg_state)}), 32'({1'b0, 4'(S_IDLE)}));
    check({tag, "_keeps_crc_fail"}, 32'(ocrc_fail), 32'(exp_fail_state));
  endtask

  initial begin
    rx_vec_t v;
    checks = 0;
    errors = 0;
    exp_fail_state = 1'b0;
    rst = 1'b1;
    idata = 4'hF;
    istart_recv = 1'b0;
    istart_send = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    rx_tab[0] = '{pattern: 0, flip_line: -1, flip_bit: 0,  end_nib: 4'hF, extras: 1'b0, exp_fail: 1'b0};
    rx_tab[1] = '{pattern: 0, flip_line: 2,  flip_bit: 9,  end_nib: 4'hF, extras: 1'b0, exp_fail: 1'b1};
    rx_tab[2] = '{pattern: 1, flip_line: -1, flip_bit: 0,  end_nib: 4'h7, extras: 1'b0, exp_fail: 1'b1};
    rx_tab[3] = '{pattern: 1, flip_line: -1, flip_bit: 0,  end_nib: 4'hF, extras: 1'b1, exp_fail: 1'b0};
    rx_tab[4] = '{pattern: 2, flip_line: 0,  flip_bit: 15, end_nib: 4'hF, extras: 1'b0, exp_fail: 1'b1};

    // reset values
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_odata", 32'(odata), 32'hF);
    check("rst_oe", 32'(ooe), 32'(0));
    check("rst_addr", 32'(oaddr), 32'(0));
    check("rst_wdata", 32'(owdata), 32'(0));
    check("rst_wen", 32'(owrite_en), 32'(0));
    check("rst_crc_fail", 32'(ocrc_fail), 32'(0));
    check("rst_done", 32'(odone), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // async reset in the middle of a write block
    istart_recv = 1'b1;
    step();
    istart_recv = 1'b0;
    idata = 4'h0;
    step();
    for (int k = 0; k < 5; k++) begin
      idata = 4'(k + 3);
      exp_q.push_back({10'(k), 4'(k + 3)});
      step();
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_async", 32'({ooe, odata, owrite_en}), 32'({1'b0, 4'hF, 1'b0}));
    step();
    check("abort_next_cycle", 32'({ooe, odata, owrite_en}), 32'({1'b0, 4'hF, 1'b0}));
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    idata = 4'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_stays_idle", 32'({owrite_en, 4'(dbg_state)}), 32'({1'b0, 4'(S_IDLE)}));
    end
    idata = 4'hF;
    check("abort_writes_seen", 32'(exp_q.size()), 32'(0));
    step();

    // table-driven host writes
    for (int i = 0; i < 5; i++) begin
      do_receive(rx_tab[i], $sformatf("rx_tab%0d", i));
      repeat ($urandom_range(1, 3)) step();
    end

    // read block n[3:0] after a failed receive
    do_send(1, 1'b0, "tx_count");
    step();

    // randomized host writes, expectations from the pass/fail rule
    for (int i = 0; i < 3; i++) begin
      v.pattern   = 2;
      v.flip_line = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      v.flip_bit  = $urandom_range(0, 15);
      v.end_nib   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      v.extras    = ($urandom_range(0, 1) == 1);
      v.exp_fail  = (v.flip_line >= 0) || (v.end_nib != 4'hF);
      do_receive(v, $sformatf("rx_rand%0d", i));
      step();
    end

    // random read block with a stray receive request mid-stream
    do_send(2, 1'b1, "tx_rand");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
